dualrail_word_counter: RTL

- Clocked, parametrised successor of the four-stage NCL ring counter.
- Emits a WIDTH-bit counter value as a dual-rail word, alternating DATA and NULL wavefronts under a four-phase completion handshake with full-word completeness.
- Ring latency is configurable; the block adds up/down counting, parallel load and a wrap flag.
- Sits between clocked test logic and NCL-style dual-rail consumers in the sandbox.

---
 rtl/dualrail_pkg.sv | 31 +++
 rtl/dr_word_complete.sv | 31 +++
 rtl/dualrail_word_counter.sv | 104 ++++++++++
 3 files changed

// File: rtl/dualrail_pkg.sv
// rtl/dualrail_pkg.sv - shared types, rail codes and encode helpers for the dual-rail word counter
package dualrail_pkg;

   typedef enum logic [1:0] {
      IDLE_NULL = 2'd0,
      FILL      = 2'd1,
      HOLD_DATA = 2'd2,
      DRAIN     = 2'd3
   } dr_state_t;

   localparam logic [1:0] DR_NULL  = 2'b00;
   localparam logic [1:0] DR_DATA0 = 2'b01;
   localparam logic [1:0] DR_DATA1 = 2'b10;

   // Widest word dr_encode handles; narrower callers encode per bit with dr_rail.
   localparam int DR_MAX_W = 64;

   function automatic logic [1:0] dr_rail(input logic b);
      return b ? DR_DATA1 : DR_DATA0;
   endfunction

   function automatic logic [2*DR_MAX_W-1:0] dr_encode(input logic [DR_MAX_W-1:0] v);
      logic [2*DR_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < DR_MAX_W; i++) begin
         r[2*i +: 2] = dr_rail(v[i]);
      end
      return r;
   endfunction

endpackage

// File: rtl/dr_word_complete.sv
// rtl/dr_word_complete.sv - registered hysteretic completion detector over a dual-rail word
module dr_word_complete #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               init,
   input  logic [2*WIDTH-1:0] word,
   output logic               comp
);

   logic [WIDTH-1:0] pair_set;

   always_comb begin
      pair_set = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pair_set[i] = word[2*i] | word[2*i+1];
      end
   end

   // Rises on a complete DATA word, falls on a complete NULL word, holds on anything in between.
   always_ff @(posedge clk) begin
      if (init) begin
         comp <= 1'b0;
      end else if (&pair_set) begin
         comp <= 1'b1;
      end else if (~|pair_set) begin
         comp <= 1'b0;
      end
   end

endmodule

// File: rtl/dualrail_word_counter.sv
// rtl/dualrail_word_counter.sv - counter emitting its value as alternating dual-rail DATA/NULL wavefronts
module dualrail_word_counter #(
   parameter int WIDTH       = 32,
   parameter int RING_STAGES = 4
) (
   input  logic               clk,
   input  logic               init,
   input  logic               ack_in,
   input  logic               count_en,
   input  logic               down,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_val,
   output logic [2*WIDTH-1:0] out_dr,
   output logic               out_comp,
   output logic               wrap
);
   import dualrail_pkg::*;

   localparam int LAT   = RING_STAGES - 1;
   localparam int CNT_W = $clog2(RING_STAGES);

   dr_state_t          state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [WIDTH-1:0]   value, value_nxt;
   logic [2*WIDTH-1:0] out_nxt, enc_word;
   logic               wrap_nxt;

   always_ff @(posedge clk) begin
      if (init) begin
         state <= IDLE_NULL;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE_NULL: if (!ack_in) begin
            state_nxt = FILL;
            cnt_nxt   = CNT_W'(LAT - 1);
         end
         FILL: if (cnt == '0) state_nxt = HOLD_DATA;
               else           cnt_nxt   = cnt - CNT_W'(1);
         HOLD_DATA: if (ack_in) begin
            state_nxt = DRAIN;
            cnt_nxt   = CNT_W'(LAT - 1);
         end
         DRAIN: if (cnt == '0) state_nxt = IDLE_NULL;
                else           cnt_nxt   = cnt - CNT_W'(1);
         default: state_nxt = IDLE_NULL;
      endcase
   end

   always_comb begin
      enc_word = '0;
      for (int i = 0; i < WIDTH; i++) begin
         enc_word[2*i +: 2] = dr_rail(value[i]);
      end
   end

   // The whole word switches in one register update, so consumers never see a mixed word.
   always_comb begin
      out_nxt   = out_dr;
      value_nxt = value;
      wrap_nxt  = 1'b0;
      case (state)
         FILL: if (cnt == '0) out_nxt = enc_word;
         HOLD_DATA: if (ack_in) begin
            if (load) begin
               value_nxt = load_val;
            end else if (count_en) begin
               value_nxt = down ? value - WIDTH'(1) : value + WIDTH'(1);
               wrap_nxt  = down ? (value == '0) : (value == '1);
            end
         end
         DRAIN: if (cnt == '0) out_nxt = '0;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (init) begin
         out_dr <= '0;
         value  <= '0;
         wrap   <= 1'b0;
      end else begin
         out_dr <= out_nxt;
         value  <= value_nxt;
         wrap   <= wrap_nxt;
      end
   end

   dr_word_complete #(.WIDTH(WIDTH)) u_complete (
      .clk  (clk),
      .init (init),
      .word (out_dr),
      .comp (out_comp)
   );

endmodule
